// File: rtl/drift_hist_reader_if.sv
// drift_hist_reader_if
//   Connection between the drift histogrammer and its hardware reader.
//   master : the reader. It drives pause, rdaddr and read_fin.
//            It receives filled and q_a.
//   slave  : the histogrammer side.
//   Signals:
//     pause    - hold the histogrammer while its bins are read out
//     rdaddr   - bin address presented to the histogram read port
//     read_fin - one-cycle pulse: readout done, re-initialise the histogram
//     filled   - histogrammer full flag
//     q_a      - bin count returned by the read port (CW bits)
interface drift_hist_reader_if #(
  parameter int CW = 20
);
  logic          pause;
  logic [4:0]    rdaddr;
  logic          read_fin;
  logic          filled;
  logic [CW-1:0] q_a;

  modport master (
    output pause,
    output rdaddr,
    output read_fin,
    input  filled,
    input  q_a
  );

  modport slave (
    input  pause,
    input  rdaddr,
    input  read_fin,
    output filled,
    output q_a
  );
endinterface

// File: rtl/drift_hist_reader.sv
// drift_hist_reader
//   Hardware readout of the 32-bin drift baseline histogram.
//   A readout is triggered by a start pulse or by a rising edge of filled.
//   The reader then:
//     - pauses the histogrammer,
//     - scans every bin through the read port,
//     - finds the peak bin,
//     - moves center_val toward the peak,
//     - pulses read_fin so the histogrammer re-initialises around the new baseline.
//   Ports:
//     clk, rst_n  - clock; asynchronous active-low reset
//     hist        - histogram-side bus (pause, rdaddr, read_fin, filled, q_a)
//     start       - single-cycle readout request, honoured only when idle
//     center_set  - idle only: load center_in into center_val
//     center_in   - manual center value
//     center_val  - current baseline
//     peak_bin    - winning bin of the last scan
//     peak_count  - count in the winning bin
//     busy        - high whenever a readout is in progress
//     empty_err   - last scan saw only empty bins
module drift_hist_reader #(
  parameter int NBINS    = 32,
  parameter int CW       = 20,
  parameter int DW       = 14,
  parameter int RD_LAT   = 3,
  parameter int SETTLE   = 2,
  parameter int CTR_INIT = 8192
) (
  input  logic                clk,
  input  logic                rst_n,
  drift_hist_reader_if.master hist,
  input  logic                start,
  input  logic                center_set,
  input  logic [DW-1:0]       center_in,
  output logic [DW-1:0]       center_val,
  output logic [4:0]          peak_bin,
  output logic [CW-1:0]       peak_count,
  output logic                busy,
  output logic                empty_err
);

  typedef enum logic [2:0] {IDLE, REQ, SCAN, CALC, FIN} state_e;

  localparam int CNTW = $clog2(NBINS + RD_LAT + SETTLE + 1);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] SCAN_LAST   = CNTW'(NBINS + RD_LAT - 1);
  localparam logic [CNTW-1:0] LAT_C       = CNTW'(RD_LAT);
  localparam logic [CNTW-1:0] NBINS_C     = CNTW'(NBINS);
  localparam logic [4:0]      LAST_BIN    = 5'(NBINS - 1);

  // Two bits beyond DW: one for the sign and one guard bit.
  // The guard bit stops center + 16 at the top of the range from wrapping
  // negative before the result is saturated.
  localparam int XW = DW + 2;
  localparam logic signed [XW-1:0] MID       = XW'(15);
  localparam logic signed [XW-1:0] OFF_OVER  = XW'(16);
  localparam logic signed [XW-1:0] OFF_UNDER = XW'(-15);
  localparam logic signed [XW-1:0] MAXV      = XW'((1 << DW) - 1);

  state_e        state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic          filled_q, filled_d;
  logic [CW-1:0] max_q, max_d;
  logic [4:0]    maxbin_q, maxbin_d;
  logic [CW-1:0] under_q, under_d;
  logic [CW-1:0] over_q, over_d;
  logic [DW-1:0] center_new_q, center_new_d;
  logic [DW-1:0] center_val_q, center_val_d;
  logic [4:0]    peak_bin_q, peak_bin_d;
  logic [CW-1:0] peak_count_q, peak_count_d;
  logic          empty_err_q, empty_err_d;

  logic                 all_zero;
  logic [4:0]           bin_idx;
  logic signed [XW-1:0] base, offs, sum;
  logic [DW-1:0]        center_calc;

  // Candidate new center from the finished scan.
  // Overflow wins over underflow, which wins over the in-range peak.
  always_comb begin
    all_zero    = (max_q == '0) && (under_q == '0) && (over_q == '0);
    base        = signed'(XW'(center_val_q));
    offs        = signed'(XW'(maxbin_q)) - MID;
    if (over_q > max_q) begin
      offs = OFF_OVER;
    end else if (under_q > max_q) begin
      offs = OFF_UNDER;
    end
    sum         = base + offs;
    center_calc = sum[DW-1:0];
    if (sum[XW-1]) begin
      center_calc = '0;
    end else if (sum > MAXV) begin
      center_calc = '1;
    end
  end

  // The bin whose data is on q_a now was addressed RD_LAT cycles ago.
  assign bin_idx = 5'(cnt_q - LAT_C);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    filled_d     = hist.filled;
    max_d        = max_q;
    maxbin_d     = maxbin_q;
    under_d      = under_q;
    over_d       = over_q;
    center_new_d = center_new_q;
    center_val_d = center_val_q;
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;
    empty_err_d  = empty_err_q;

    case (state_q)
      IDLE: begin
        // A manual load takes the cycle; a simultaneous start is dropped.
        if (center_set) begin
          center_val_d = center_in;
        end else if (start || (hist.filled && !filled_q)) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end

      REQ: begin
        max_d    = '0;
        maxbin_d = '0;
        under_d  = '0;
        over_d   = '0;
        if (cnt_q == SETTLE_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      SCAN: begin
        if (cnt_q >= LAT_C) begin
          if (bin_idx == '0) begin
            under_d = hist.q_a;
          end else if (bin_idx == LAST_BIN) begin
            over_d = hist.q_a;
          end else if (hist.q_a > max_q) begin
            // Strict compare keeps the lowest index on ties.
            max_d    = hist.q_a;
            maxbin_d = bin_idx;
          end
        end
        if (cnt_q == SCAN_LAST) begin
          state_d = CALC;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      CALC: begin
        peak_bin_d   = maxbin_q;
        peak_count_d = max_q;
        empty_err_d  = all_zero;
        center_new_d = all_zero ? center_val_q : center_calc;
        state_d      = FIN;
      end

      FIN: begin
        center_val_d = center_new_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      filled_q     <= 1'b0;
      max_q        <= '0;
      maxbin_q     <= '0;
      under_q      <= '0;
      over_q       <= '0;
      center_new_q <= DW'(CTR_INIT);
      center_val_q <= DW'(CTR_INIT);
      peak_bin_q   <= '0;
      peak_count_q <= '0;
      empty_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      filled_q     <= filled_d;
      max_q        <= max_d;
      maxbin_q     <= maxbin_d;
      under_q      <= under_d;
      over_q       <= over_d;
      center_new_q <= center_new_d;
      center_val_q <= center_val_d;
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
      empty_err_q  <= empty_err_d;
    end
  end

  assign hist.pause    = (state_q == REQ) || (state_q == SCAN) || (state_q == CALC);
  assign hist.read_fin = (state_q == FIN);
  assign hist.rdaddr   = ((state_q == SCAN) && (cnt_q < NBINS_C)) ? cnt_q[4:0] : '0;
  assign busy          = (state_q != IDLE);
  assign center_val    = center_val_q;
  assign peak_bin      = peak_bin_q;
  assign peak_count    = peak_count_q;
  assign empty_err     = empty_err_q;

endmodule

// File: tb/tb_drift_hist_reader.sv
// tb_drift_hist_reader
//   Drives two readers side by side, one with RD_LAT=3 and one with RD_LAT=1.
//   Each reader has its own pipelined RAM model, and both share one bin array.
//   Results are compared against a plain-arithmetic model of the scan.
module tb_drift_hist_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        filled;
  logic        center_set;
  logic [13:0] center_in;

  logic [13:0] center_val3, center_val1;
  logic [4:0]  peak_bin3, peak_bin1;
  logic [19:0] peak_count3, peak_count1;
  logic        busy3, busy1, empty_err3, empty_err1;

  logic [19:0] mem [32];
  logic [4:0]  pipe3 [3];
  logic [4:0]  pipe1;

  int checks = 0;
  int errors = 0;
  int exp_center;

  int rf3, rf1, overlap, pz3, pz1;
  logic [31:0] mask3, mask1;

  always #5 clk = ~clk;

  drift_hist_reader_if #(.CW(20)) hif3 ();
  drift_hist_reader_if #(.CW(20)) hif1 ();

  assign hif3.filled = filled;
  assign hif1.filled = filled;

  // RAM models: q_a shows mem[rdaddr] RD_LAT cycles after the address is driven.
  always @(posedge clk) begin
    pipe3[0] <= hif3.rdaddr;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    pipe1    <= hif1.rdaddr;
  end
  assign hif3.q_a = mem[pipe3[2]];
  assign hif1.q_a = mem[pipe1];

  drift_hist_reader #(.RD_LAT(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .hist       (hif3),
    .start      (start),
    .center_set (center_set),
    .center_in  (center_in),
    .center_val (center_val3),
    .peak_bin   (peak_bin3),
    .peak_count (peak_count3),
    .busy       (busy3),
    .empty_err  (empty_err3)
  );

  drift_hist_reader #(.RD_LAT(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .hist       (hif1),
    .start      (start),
    .center_set (center_set),
    .center_in  (center_in),
    .center_val (center_val1),
    .peak_bin   (peak_bin1),
    .peak_count (peak_count1),
    .busy       (busy1),
    .empty_err  (empty_err1)
  );

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (hif3.read_fin) rf3++;
    if (hif1.read_fin) rf1++;
    if (hif3.read_fin && hif3.pause) overlap++;
    if (hif1.read_fin && hif1.pause) overlap++;
    if (hif3.pause) begin
      pz3++;
      mask3 = mask3 | (32'd1 << hif3.rdaddr);
    end
    if (hif1.pause) begin
      pz1++;
      mask1 = mask1 | (32'd1 << hif1.rdaddr);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMon();
    rf3 = 0; rf1 = 0; overlap = 0; pz3 = 0; pz1 = 0;
    mask3 = '0; mask1 = '0;
  endtask

  // Reference scan.
  // The peak is the first maximum over the in-range bins 1..30.
  // A bin b means an offset of b-15.
  // If the overflow bin beats the peak, the center moves +16.
  // Otherwise, if the underflow bin beats the peak, the center moves -15.
  // The result is clamped to 0..16383.
  function automatic void modelScan(inout int ctr, output int pb, output int pc, output bit emp);
    int mx;
    bit any_nz;
    mx = 0; pb = 0; any_nz = 1'b0;
    for (int b = 0; b < 32; b++) if (mem[b] != 0) any_nz = 1'b1;
    for (int b = 1; b <= 30; b++) begin
      if (int'(mem[b]) > mx) begin
        mx = int'(mem[b]);
        pb = b;
      end
    end
    pc  = mx;
    emp = !any_nz;
    if (any_nz) begin
      if (int'(mem[31]) > mx)      ctr = ctr + 16;
      else if (int'(mem[0]) > mx)  ctr = ctr - 15;
      else                         ctr = ctr + pb - 15;
      if (ctr < 0)     ctr = 0;
      if (ctr > 16383) ctr = 16383;
    end
  endfunction

  task automatic checkResults(input string tag, input int ctr, input int pb, input int pc, input bit emp);
    checkOutput({tag, "_l3_center"}, int'(center_val3), ctr);
    checkOutput({tag, "_l1_center"}, int'(center_val1), ctr);
    checkOutput({tag, "_l3_peak_bin"}, int'(peak_bin3), pb);
    checkOutput({tag, "_l1_peak_bin"}, int'(peak_bin1), pb);
    checkOutput({tag, "_l3_peak_count"}, int'(peak_count3), pc);
    checkOutput({tag, "_l1_peak_count"}, int'(peak_count1), pc);
    checkOutput({tag, "_l3_empty"}, int'(empty_err3), int'(emp));
    checkOutput({tag, "_l1_empty"}, int'(empty_err1), int'(emp));
    checkOutput({tag, "_l3_read_fin_pulses"}, rf3, 1);
    checkOutput({tag, "_l1_read_fin_pulses"}, rf1, 1);
    checkOutput({tag, "_fin_while_paused"}, overlap, 0);
    checkOutput({tag, "_l3_all_addr"}, int'(mask3 == 32'hFFFF_FFFF), 1);
    checkOutput({tag, "_l1_all_addr"}, int'(mask1 == 32'hFFFF_FFFF), 1);
  endtask

  // One readout triggered by start or by a filled edge.
  // filled is held high for the whole readout and a few cycles after it.
  // extra_start fires a second start mid-scan; it must be dropped.
  task automatic applyStimulus(input bit use_filled, input bit extra_start, input string tag);
    int ctr, pb, pc, n;
    bit emp;
    ctr = exp_center;
    modelScan(ctr, pb, pc, emp);
    clearMon();
    if (use_filled) filled = 1'b1;
    else            start  = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(rf3 > 0 && rf1 > 0 && !busy3 && !busy1) && n < 300) begin
      start = (extra_start && n == 10);
      tick();
      n++;
    end
    start = 1'b0;
    checkOutput({tag, "_done_in_time"}, int'(n < 300), 1);
    repeat (6) tick();
    checkOutput({tag, "_l3_no_retrigger"}, int'(busy3), 0);
    checkOutput({tag, "_l1_no_retrigger"}, int'(busy1), 0);
    checkResults(tag, ctr, pb, pc, emp);
    exp_center = ctr;
    filled = 1'b0;
    tick();
  endtask

  task automatic setCenter(input int v);
    center_set = 1'b1;
    center_in  = 14'(v);
    tick();
    center_set = 1'b0;
    exp_center = v;
    tick();
    checkOutput("set_l3_center", int'(center_val3), v);
    checkOutput("set_l1_center", int'(center_val1), v);
  endtask

  task automatic clearMem();
    for (int b = 0; b < 32; b++) mem[b] = '0;
  endtask

  task automatic randomMem();
    int r;
    for (int b = 0; b < 32; b++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      mem[b] = '0;
      else if (r < 8) mem[b] = 20'($urandom_range(1, 4));
      else            mem[b] = 20'($urandom_range(0, 1048575));
    end
  endtask

  initial begin
    int n, v;
    rst_n = 1'b0; start = 1'b0; filled = 1'b0;
    center_set = 1'b0; center_in = '0;
    clearMem();
    clearMon();
    exp_center = 8192;
    repeat (3) tick();

    checkOutput("reset_pause", int'(hif3.pause), 0);
    checkOutput("reset_read_fin", int'(hif3.read_fin), 0);
    checkOutput("reset_rdaddr", int'(hif3.rdaddr), 0);
    checkOutput("reset_busy", int'(busy3), 0);
    checkOutput("reset_center", int'(center_val3), 8192);
    checkOutput("reset_peak_bin", int'(peak_bin3), 0);
    checkOutput("reset_peak_count", int'(peak_count3), 0);
    checkOutput("reset_empty", int'(empty_err3), 0);
    rst_n = 1'b1;
    tick();

    // Single peak at bin 20.
    mem[20] = 20'd500;
    applyStimulus(1'b0, 1'b0, "t1_peak20");

    // Tie between bins 7 and 22; the lowest index wins.
    setCenter(8192);
    clearMem(); mem[7] = 20'd300; mem[22] = 20'd300;
    applyStimulus(1'b0, 1'b0, "t2_tie");

    // Overflow wins, then saturation at the top of the range.
    setCenter(8192);
    clearMem(); mem[31] = 20'd1000; mem[15] = 20'd10;
    applyStimulus(1'b0, 1'b0, "t3_over");
    setCenter(16380);
    applyStimulus(1'b0, 1'b0, "t3_sat");

    // Empty histogram.
    clearMem();
    applyStimulus(1'b0, 1'b0, "t4_empty");

    // Asynchronous reset in the middle of a scan.
    randomMem();
    clearMon();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (hif3.rdaddr != 5'd12 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("t5_reach_addr12", int'(n < 100), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_l3_pause", int'(hif3.pause), 0);
    checkOutput("t5_l1_pause", int'(hif1.pause), 0);
    checkOutput("t5_l3_center", int'(center_val3), 8192);
    checkOutput("t5_l1_center", int'(center_val1), 8192);
    checkOutput("t5_busy", int'(busy3), 0);
    tick();
    rst_n = 1'b1;
    exp_center = 8192;
    tick();
    mem[1] = 20'd7; mem[30] = 20'd9;
    applyStimulus(1'b0, 1'b0, "t5_rescan");

    // center_set has priority over a same-cycle start.
    clearMon();
    center_set = 1'b1; center_in = 14'd100; start = 1'b1;
    tick();
    center_set = 1'b0; start = 1'b0;
    repeat (5) tick();
    exp_center = 100;
    checkOutput("t6_center", int'(center_val3), 100);
    checkOutput("t6_busy", int'(busy3), 0);
    checkOutput("t6_no_pause", pz3 + pz1, 0);

    // filled held high for 200 cycles gives exactly one readout.
    randomMem();
    begin
      int ctr, pb, pc;
      bit emp;
      ctr = exp_center;
      modelScan(ctr, pb, pc, emp);
      clearMon();
      filled = 1'b1;
      repeat (200) tick();
      filled = 1'b0;
      tick();
      checkResults("t6_hold", ctr, pb, pc, emp);
      exp_center = ctr;
    end

    // Randomised readouts.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       v = 5;
          1:       v = 16380;
          default: v = $urandom_range(0, 16383);
        endcase
        setCenter(v);
      end
      if (i % 7 == 3) clearMem();
      else            randomMem();
      applyStimulus(1'(i % 2), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
